// File: rtl/soc_arb_pkg.sv
// rtl/soc_arb_pkg.sv - shared types and constants for the SoC bus arbiter
package soc_arb_pkg;

  localparam int ARB_CNT_W = 16;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/soc_rr_picker.sv
// rtl/soc_rr_picker.sv - combinational round-robin winner search
// The search begins one past last_grant_i and wraps modulo N.
module soc_rr_picker #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_grant_i,
  output logic [IW-1:0] winner_o,
  output logic          any_req_o
);

  logic [IW:0] cand;
  logic        found;

  always_comb begin
    winner_o = last_grant_i;
    found    = 1'b0;
    cand     = '0;
    for (int k = 1; k <= N; k++) begin
      // One extra bit keeps last_grant + k from overflowing before the wrap.
      cand = {1'b0, last_grant_i} + (IW + 1)'(k);
      if (cand >= (IW + 1)'(N)) begin
        cand = cand - (IW + 1)'(N);
      end
      if (!found && req_i[cand[IW-1:0]]) begin
        winner_o = cand[IW-1:0];
        found    = 1'b1;
      end
    end
    any_req_o = |req_i;
  end

endmodule

// File: rtl/soc_bus_arbiter.sv
// rtl/soc_bus_arbiter.sv - round-robin arbiter sharing one slave port among masters
// Owner's request is forwarded combinationally while BUSY; completion strobes are same-cycle.
module soc_bus_arbiter
  import soc_arb_pkg::*;
#(
  parameter int MASTER_COUNT   = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      res,
  input  logic [MASTER_COUNT-1:0]   m_req,
  input  logic [32*MASTER_COUNT-1:0] m_addr,
  input  logic [MASTER_COUNT-1:0]   m_wr,
  input  logic [32*MASTER_COUNT-1:0] m_wdata,
  input  logic [4*MASTER_COUNT-1:0] m_wmask,
  output logic [31:0]               m_rdata,
  output logic [MASTER_COUNT-1:0]   m_ready,
  output logic [MASTER_COUNT-1:0]   m_err,
  output logic                      s_req,
  output logic [31:0]               s_addr,
  output logic                      s_wr,
  output logic [31:0]               s_wdata,
  output logic [3:0]                s_wmask,
  input  logic [31:0]               s_rdata,
  input  logic                      s_ready,
  output logic [2:0]                grant_id,
  output logic                      busy
);

  localparam int IW = $clog2(MASTER_COUNT);
  localparam logic [ARB_CNT_W-1:0] TIMEOUT_VAL = ARB_CNT_W'(TIMEOUT_CYCLES);

  arb_state_t           state_q, state_d;
  logic [IW-1:0]        owner_q, owner_d;
  logic [IW-1:0]        last_grant_q, last_grant_d;
  logic [ARB_CNT_W-1:0] wait_q, wait_d;

  logic [IW-1:0]           winner;
  logic                    any_req;
  logic [31:0]             own_addr, own_wdata;
  logic [3:0]              own_wmask;
  logic                    own_wr;
  logic [MASTER_COUNT-1:0] owner_oh;
  logic                    is_busy, done, timed_out;

  soc_rr_picker #(
    .N  (MASTER_COUNT),
    .IW (IW)
  ) u_picker (
    .req_i        (m_req),
    .last_grant_i (last_grant_q),
    .winner_o     (winner),
    .any_req_o    (any_req)
  );

  always_comb begin
    own_addr  = '0;
    own_wdata = '0;
    own_wmask = '0;
    own_wr    = 1'b0;
    owner_oh  = '0;
    for (int i = 0; i < MASTER_COUNT; i++) begin
      if (owner_q == IW'(i)) begin
        own_addr    = m_addr[32*i +: 32];
        own_wdata   = m_wdata[32*i +: 32];
        own_wmask   = m_wmask[4*i +: 4];
        own_wr      = m_wr[i];
        owner_oh[i] = 1'b1;
      end
    end
  end

  assign is_busy   = (state_q == ARB_BUSY);
  assign done      = is_busy && s_ready;
  // A ready slave in the timeout cycle wins over the error.
  assign timed_out = is_busy && !s_ready && (wait_q == TIMEOUT_VAL);

  always_comb begin
    s_req    = is_busy;
    s_addr   = is_busy ? own_addr  : 32'h0;
    s_wr     = is_busy ? own_wr    : 1'b0;
    s_wdata  = is_busy ? own_wdata : 32'h0;
    s_wmask  = is_busy ? own_wmask : 4'h0;
    m_ready  = (done || timed_out) ? owner_oh : '0;
    m_err    = timed_out ? owner_oh : '0;
    m_rdata  = done ? s_rdata : 32'h0;
    grant_id = 3'(owner_q);
    busy     = is_busy;
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    wait_d       = wait_q;
    case (state_q)
      ARB_IDLE: begin
        if (any_req) begin
          state_d = ARB_BUSY;
          owner_d = winner;
          wait_d  = '0;
        end
      end
      ARB_BUSY: begin
        if (done || timed_out) begin
          state_d      = ARB_IDLE;
          last_grant_d = owner_q;
        end else begin
          wait_d = wait_q + ARB_CNT_W'(1);
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q      <= ARB_IDLE;
      owner_q      <= '0;
      last_grant_q <= IW'(MASTER_COUNT - 1);
      wait_q       <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      wait_q       <= wait_d;
    end
  end

endmodule

// File: tb/tb_soc_bus_arbiter.sv
// tb/tb_soc_bus_arbiter.sv - directed self-checking bench for soc_bus_arbiter
module tb_soc_bus_arbiter;

  localparam int MC = 3;

  logic          clk = 1'b0;
  logic          res;
  logic [MC-1:0] m_req;
  logic [32*MC-1:0] m_addr;
  logic [MC-1:0] m_wr;
  logic [32*MC-1:0] m_wdata;
  logic [4*MC-1:0]  m_wmask;
  logic [31:0]   m_rdata;
  logic [MC-1:0] m_ready;
  logic [MC-1:0] m_err;
  logic          s_req;
  logic [31:0]   s_addr;
  logic          s_wr;
  logic [31:0]   s_wdata;
  logic [3:0]    s_wmask;
  logic [31:0]   s_rdata;
  logic          s_ready;
  logic [2:0]    grant_id;
  logic          busy;

  int tests = 0;
  int fails = 0;

  soc_bus_arbiter #(
    .MASTER_COUNT   (MC),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk      (clk),
    .res      (res),
    .m_req    (m_req),
    .m_addr   (m_addr),
    .m_wr     (m_wr),
    .m_wdata  (m_wdata),
    .m_wmask  (m_wmask),
    .m_rdata  (m_rdata),
    .m_ready  (m_ready),
    .m_err    (m_err),
    .s_req    (s_req),
    .s_addr   (s_addr),
    .s_wr     (s_wr),
    .s_wdata  (s_wdata),
    .s_wmask  (s_wmask),
    .s_rdata  (s_rdata),
    .s_ready  (s_ready),
    .grant_id (grant_id),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    res = 1'b1;
    tick();
    res = 1'b0;
  endtask

  initial begin
    res     = 1'b1;
    m_req   = '0;
    m_addr  = '0;
    m_wr    = '0;
    m_wdata = '0;
    m_wmask = '0;
    s_rdata = '0;
    s_ready = 1'b0;

    // Reset state
    #3;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sreq", 32'(s_req), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    chk("rst_mready", 32'(m_ready), 32'd0);
    chk("rst_rdata", m_rdata, 32'd0);
    tick();
    tick();
    res = 1'b0;

    // Single read by master 1, slave ready two cycles after s_req
    m_req = 3'b010;
    m_addr[32*1 +: 32] = 32'h1000_0004;
    m_addr[32*0 +: 32] = 32'hAAAA_0000;
    m_addr[32*2 +: 32] = 32'hBBBB_0000;
    settle();
    chk("single_idle_sreq", 32'(s_req), 32'd0);
    tick();
    m_req = 3'b000;
    settle();
    chk("single_sreq", 32'(s_req), 32'd1);
    chk("single_grant", 32'(grant_id), 32'd1);
    chk("single_addr", s_addr, 32'h1000_0004);
    chk("single_wr", 32'(s_wr), 32'd0);
    tick();
    settle();
    chk("single_wait_ready", 32'(m_ready), 32'd0);
    tick();
    s_ready = 1'b1;
    s_rdata = 32'hDEAD_BEEF;
    settle();
    chk("single_ready", 32'(m_ready), 32'b010);
    chk("single_rdata", m_rdata, 32'hDEAD_BEEF);
    chk("single_err", 32'(m_err), 32'd0);
    tick();
    s_ready = 1'b0;
    settle();
    chk("single_after_busy", 32'(busy), 32'd0);
    chk("single_after_sreq", 32'(s_req), 32'd0);
    chk("single_after_ready", 32'(m_ready), 32'd0);
    chk("single_after_rdata", m_rdata, 32'd0);

    // Fairness from a fresh reset: 0,1,2,0,1,2 with an idle gap each time
    do_reset();
    m_req = 3'b111;
    for (int g = 0; g < 6; g++) begin
      settle();
      chk("fair_idle_sreq", 32'(s_req), 32'd0);
      tick();
      settle();
      chk("fair_grant", 32'(grant_id), 32'(g % 3));
      chk("fair_sreq", 32'(s_req), 32'd1);
      tick();
      s_ready = 1'b1;
      settle();
      chk("fair_ready", 32'(m_ready), 32'(1 << (g % 3)));
      tick();
      s_ready = 1'b0;
    end
    m_req = 3'b000;
    settle();
    chk("fair_end_idle", 32'(busy), 32'd0);

    // Timeout on master 2 write; master 0 request held pending meanwhile
    tick();
    m_req = 3'b100;
    m_wr  = 3'b100;
    m_wdata[32*2 +: 32] = 32'h0BAD_F00D;
    s_rdata = 32'hFFFF_FFFF;
    tick();
    m_req = 3'b101;
    settle();
    chk("to_grant", 32'(grant_id), 32'd2);
    chk("to_wr", 32'(s_wr), 32'd1);
    tick();
    for (int k = 2; k <= 4; k++) begin
      settle();
      chk("to_wait_err", 32'(m_err), 32'd0);
      chk("to_wait_ready", 32'(m_ready), 32'd0);
      chk("to_wait_grant", 32'(grant_id), 32'd2);
      tick();
    end
    settle();
    chk("to_err", 32'(m_err), 32'b100);
    chk("to_ready", 32'(m_ready), 32'b100);
    chk("to_rdata", m_rdata, 32'd0);
    tick();
    settle();
    chk("to_idle_busy", 32'(busy), 32'd0);
    chk("to_idle_err", 32'(m_err), 32'd0);
    tick();
    m_req = 3'b000;
    settle();
    chk("to_next_grant", 32'(grant_id), 32'd0);
    chk("to_next_busy", 32'(busy), 32'd1);
    s_ready = 1'b1;
    #1;
    chk("to_next_ready", 32'(m_ready), 32'b001);
    tick();
    s_ready = 1'b0;
    m_wr = '0;

    // s_ready arrives exactly in the timeout cycle
    m_req = 3'b010;
    tick();
    m_req = 3'b000;
    for (int k = 1; k <= 4; k++) begin
      settle();
      chk("co_wait_ready", 32'(m_ready), 32'd0);
      tick();
    end
    s_ready = 1'b1;
    s_rdata = 32'hCAFE_F00D;
    settle();
    chk("co_ready", 32'(m_ready), 32'b010);
    chk("co_err", 32'(m_err), 32'd0);
    chk("co_rdata", m_rdata, 32'hCAFE_F00D);
    tick();
    s_ready = 1'b0;
    settle();
    chk("co_idle", 32'(busy), 32'd0);

    // Write forwarding for master 0, request dropped after grant
    m_req = 3'b001;
    m_wr  = 3'b111;
    m_wdata[32*0 +: 32] = 32'h1234_5678;
    m_wdata[32*1 +: 32] = 32'h5555_5555;
    m_wdata[32*2 +: 32] = 32'h6666_6666;
    m_wmask = {4'b1111, 4'b1100, 4'b0011};
    tick();
    m_req = 3'b000;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) s_ready = 1'b1;
      settle();
      chk("wr_sreq", 32'(s_req), 32'd1);
      chk("wr_wdata", s_wdata, 32'h1234_5678);
      chk("wr_wmask", 32'(s_wmask), 32'b0011);
      chk("wr_wr", 32'(s_wr), 32'd1);
      tick();
    end
    s_ready = 1'b0;
    m_wr = '0;
    settle();
    chk("wr_idle_wdata", s_wdata, 32'd0);

    // Reset in the middle of a master 1 transaction
    m_req = 3'b010;
    tick();
    m_req = 3'b000;
    settle();
    chk("rm_grant", 32'(grant_id), 32'd1);
    chk("rm_sreq_before", 32'(s_req), 32'd1);
    res = 1'b1;
    s_ready = 1'b1;
    #1;
    chk("rm_sreq", 32'(s_req), 32'd0);
    chk("rm_ready", 32'(m_ready), 32'd0);
    chk("rm_err", 32'(m_err), 32'd0);
    chk("rm_busy", 32'(busy), 32'd0);
    tick();
    res = 1'b0;
    s_ready = 1'b0;
    m_req = 3'b011;
    settle();
    chk("rm_post_idle", 32'(busy), 32'd0);
    tick();
    settle();
    chk("rm_post_grant", 32'(grant_id), 32'd0);
    chk("rm_post_busy", 32'(busy), 32'd1);
    s_ready = 1'b1;
    #1;
    chk("rm_post_ready", 32'(m_ready), 32'b001);
    tick();
    s_ready = 1'b0;
    m_req = 3'b000;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/soc_bus_arbiter.md
SOC_BUS_ARBITER -- requirements
Module: soc_bus_arbiter

Interface
REQ-001 Parameter MASTER_COUNT, default 3: number of requesting masters, legal range 2..8.
REQ-002 Parameter TIMEOUT_CYCLES, default 255: maximum number of cycles a granted transaction may wait for slave ready, legal range 1..65535.
REQ-003 Port clk, input, 1: single clock for all logic.
REQ-004 Port res, input, 1: asynchronous active-high reset.
REQ-005 Port m_req, input, MASTER_COUNT: per-master transaction request.
REQ-006 Port m_addr, input, 32*MASTER_COUNT: per-master address; master i occupies bits [32i+31:32i].
REQ-007 Port m_wr, input, MASTER_COUNT: per-master write enable (0 = read).
REQ-008 Port m_wdata, input, 32*MASTER_COUNT: per-master write data.
REQ-009 Port m_wmask, input, 4*MASTER_COUNT: per-master byte write mask.
REQ-010 Port m_rdata, output, 32: read data, broadcast to all masters.
REQ-011 Port m_ready, output, MASTER_COUNT: per-master completion strobe.
REQ-012 Port m_err, output, MASTER_COUNT: per-master timeout error strobe.
REQ-013 Port s_req, s_addr, s_wr, s_wdata, s_wmask, outputs, 1/32/1/32/4: shared slave request.
REQ-014 Port s_rdata, s_ready, inputs, 32/1: slave response.
REQ-015 Port grant_id, output, 3: index of the current owner, valid while busy.
REQ-016 Port busy, output, 1: high while a transaction is granted.

Function
REQ-017 FSM states: IDLE and BUSY only.
REQ-018 In IDLE with any m_req bit high, the arbiter SHALL register the winner into owner, enter BUSY, and assert s_req on the next cycle.
  - Latency from m_req high in IDLE to s_req high is exactly 1 cycle.
REQ-019 Winner selection SHALL be round-robin: search starts at last_grant+1 modulo MASTER_COUNT and takes the first requesting index.
REQ-020 In BUSY, the owner's addr, wr, wdata, and wmask SHALL drive s_* combinationally, and s_req SHALL stay high.
REQ-021 In BUSY with s_ready high, the arbiter SHALL:
  - pulse m_ready[owner] for that same cycle;
  - pass s_rdata through to m_rdata;
  - set last_grant = owner;
  - return to IDLE.
REQ-022 At least one IDLE cycle SHALL separate consecutive grants; s_req is low in that cycle.
REQ-023 Wait counter rules:
  - 16-bit wait counter, cleared on entry to BUSY, incremented each BUSY cycle without s_ready.
  - When the counter equals TIMEOUT_CYCLES and s_ready is low, pulse m_err[owner] and m_ready[owner] together.
  - Drive m_rdata to 32'h0, set last_grant = owner, go IDLE.
REQ-024 If s_ready and the timeout coincide, s_ready SHALL win: normal completion, no m_err.
REQ-025 A master deasserting m_req while it is owner SHALL NOT abort the transaction; it continues until s_ready or timeout.
REQ-026 Requests from non-owners during BUSY SHALL be held pending, with no effect until IDLE.
REQ-027 When not BUSY, the arbiter SHALL hold the following:
  - s_* outputs at 0;
  - m_ready and m_err at 0;
  - m_rdata at 0.
REQ-028 grant_id SHALL equal owner, zero-extended to 3 bits.

Reset
REQ-029 While res is high, the following SHALL hold asynchronously:
  - state = IDLE, owner = 0, last_grant = MASTER_COUNT-1, counter = 0;
  - all outputs 0.
REQ-030 res asserted mid-transaction SHALL drop s_req immediately and issue no m_ready or m_err for the aborted transaction.
REQ-031 After res deasserts, master 0 SHALL have first priority.

Structure
REQ-032 Shared package soc_arb_pkg SHALL hold:
  - the arb_state_t enum {ARB_IDLE, ARB_BUSY};
  - the 16-bit counter width constant.
REQ-033 Sub-module soc_rr_picker SHALL be the combinational round-robin winner search (inputs req vector and last_grant; outputs winner index and any_req).
REQ-034 All state SHALL be in one always_ff block with asynchronous reset on res.

Verification
REQ-035 Single request: m_req=3'b010, addr=32'h1000_0004, read, slave gives s_ready 2 cycles after s_req with s_rdata=32'hDEADBEEF -> s_req high 1 cycle after m_req, m_ready[1] pulses once, m_rdata=32'hDEADBEEF.
REQ-036 Fairness: m_req=3'b111 held constant, slave ready after 1 cycle -> grant order 0,1,2,0,1,2 with one IDLE cycle between grants.
REQ-037 Timeout: TIMEOUT_CYCLES=4, m_req[2] write, s_ready never high -> m_err[2] and m_ready[2] pulse together 4 BUSY cycles after grant, m_rdata=0, then master 0 is granted if requesting.
REQ-038 Coincidence: s_ready asserted in the exact timeout cycle -> m_ready only, m_err stays 0.
REQ-039 Reset mid-transaction: res pulsed while BUSY for master 1 -> s_req low immediately, no m_ready, first grant after reset goes to master 0 when m_req=3'b011.
REQ-040 Write forwarding: master 0 wr=1, wdata=32'h1234_5678, wmask=4'b0011 -> s_wdata/s_wmask match exactly for every BUSY cycle, even when m_req[0] drops after grant.
